// File: rtl/rf_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write-port logic.
//   RF_AW / RF_DW / RF_DEPTH : geometry of the 32 x 32-bit register file
//   rf_state_t               : write-port controller states (sweep / normal)
// ---------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_AW    = 5;
    localparam int RF_DW    = 32;
    localparam int RF_DEPTH = 32;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search begins at 'ptr' and
// walks upward modulo NREQ; the first asserted request wins.
// Ports:
//   req  in  NREQ          request vector
//   ptr  in  $clog2(NREQ)  highest-priority index for this cycle
//   gnt  out NREQ          one-hot grant (all zero when no request)
//   idx  out $clog2(NREQ)  index of the granted request (0 when none)
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt,
    output logic [PW-1:0]   idx
);

    // Rotating priority scan. The 'found' flag stops later candidates from
    // overriding the first hit, which keeps the grant strictly one-hot.
    always_comb begin
        logic found;
        int   pos;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int k = 0; k < NREQ; k++) begin
            pos = (int'(ptr) + k) % NREQ;
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = PW'(pos);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wr_arbiter
// Shares the single write port of the register file between NREQ requesters
// with round-robin arbitration. Accepted writes become a registered one-hot
// enable bus plus a shared data word. After reset an optional sweep writes
// zero to every register before any request is accepted.
// Ports:
//   clk        in  1              rising-edge clock
//   reset      in  1              synchronous, active-high reset
//   req_valid  in  NREQ           per-requester write request
//   req_addr   in  NREQ*AW        packed addresses, slice i = [i*AW +: AW]
//   req_data   in  NREQ*DW        packed data,      slice i = [i*DW +: DW]
//   req_ready  out NREQ           one-hot grant (accept = valid & ready)
//   wr_en      out 2**AW          registered one-hot register enables
//   wr_data    out DW             registered write data
//   grant_id   out $clog2(NREQ)   registered index of last accepted requester
//   busy       out 1              high while the zero sweep runs
// ---------------------------------------------------------------------------
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int NREQ           = 4,
    parameter int AW             = RF_AW,
    parameter int DW             = RF_DW,
    parameter int CLEAR_ON_RESET = 1,
    parameter int ZERO_REG       = 1,
    parameter int PW             = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic [2**AW-1:0]  wr_en,
    output logic [DW-1:0]     wr_data,
    output logic [PW-1:0]     grant_id,
    output logic              busy
);

    localparam int NREG = 2**AW;

    rf_state_t        state, state_nxt;
    logic [AW-1:0]    cnt, cnt_nxt;
    logic [PW-1:0]    ptr, ptr_nxt;
    logic [NREG-1:0]  wr_en_nxt;
    logic [DW-1:0]    wr_data_nxt;
    logic [PW-1:0]    grant_id_nxt;

    logic [NREQ-1:0]  gnt;
    logic [PW-1:0]    gnt_idx;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_data;

    rr_arbiter #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_arb (
        .req  (req_valid),
        .ptr  (ptr),
        .gnt  (gnt),
        .idx  (gnt_idx)
    );

    // Grants are only exposed to requesters once the sweep is finished, so
    // nothing can be accepted while the zero writes own the port.
    assign req_ready = (state == ST_RUN) ? gnt : '0;
    assign busy      = (state == ST_CLEAR);
    assign sel_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign sel_data  = req_data[int'(gnt_idx)*DW +: DW];

    // Next-state and next-output logic. wr_en defaults to zero every cycle
    // so an enable is a single-cycle pulse; data and grant_id hold when
    // nothing is accepted. Register 0 is swept even when it is read-only,
    // since the sweep is what establishes its zero value.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        ptr_nxt      = ptr;
        wr_en_nxt    = '0;
        wr_data_nxt  = wr_data;
        grant_id_nxt = grant_id;
        case (state)
            ST_CLEAR: begin
                wr_en_nxt[cnt] = 1'b1;
                wr_data_nxt    = '0;
                cnt_nxt        = cnt + AW'(1);
                if (cnt == AW'(NREG - 1)) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (|gnt) begin
                    if (!((ZERO_REG != 0) && (sel_addr == '0))) begin
                        wr_en_nxt[sel_addr] = 1'b1;
                    end
                    wr_data_nxt  = sel_data;
                    grant_id_nxt = gnt_idx;
                    ptr_nxt      = (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + PW'(1);
                end
            end
        endcase
    end

    // State and output registers. Reset overrides everything, dropping any
    // enable that would otherwise issue and restarting the sweep at 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
            cnt      <= '0;
            ptr      <= '0;
            wr_en    <= '0;
            wr_data  <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            ptr      <= ptr_nxt;
            wr_en    <= wr_en_nxt;
            wr_data  <= wr_data_nxt;
            grant_id <= grant_id_nxt;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_regfile_wr_arbiter
// Directed bench for regfile_wr_arbiter (NREQ=4, CLEAR_ON_RESET=1,
// ZERO_REG=1). Inputs change 1ns after each rising edge; outputs are
// sampled at that point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_regfile_wr_arbiter;

    localparam int NREQ = 4;
    localparam int AW   = 5;
    localparam int DW   = 32;

    logic                clk;
    logic                reset;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic [31:0]         wr_en;
    logic [DW-1:0]       wr_data;
    logic [1:0]          grant_id;
    logic                busy;

    int total = 0;
    int bad   = 0;

    regfile_wr_arbiter #(
        .NREQ           (NREQ),
        .AW             (AW),
        .DW             (DW),
        .CLEAR_ON_RESET (1),
        .ZERO_REG       (1)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    // 10ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] onehot(input int n);
        logic [31:0] v;
        v = 32'd1;
        return v << n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic [NREQ-1:0] valid);
        reset     = rst;
        req_valid = valid;
    endtask

    task automatic setReq(input int i, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        req_addr[i*AW +: AW] = addr;
        req_data[i*DW +: DW] = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Walks a full 32-cycle sweep starting from the current (post-reset)
    // point: busy and zero ready before each edge, one-hot walk after it.
    task automatic checkSweep(input string tag, input int ncyc);
        for (int c = 1; c <= ncyc; c++) begin
            checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd1);
            checkOutput({tag, "_ready"}, {28'd0, req_ready}, 32'd0);
            tick();
            checkOutput({tag, "_wr_en"}, wr_en, onehot(c - 1));
            checkOutput({tag, "_wr_data"}, wr_data, 32'd0);
        end
    endtask

    initial begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            setReq(i, AW'(8 + i), 32'hA0 + 32'(i));
        end
        applyStimulus(1'b1, 4'b0000);
        tick();
        tick();
        tick();

        // reset state
        checkOutput("rst_wr_en", wr_en, 32'd0);
        checkOutput("rst_wr_data", wr_data, 32'd0);
        checkOutput("rst_grant_id", {30'd0, grant_id}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd1);
        checkOutput("rst_ready", {28'd0, req_ready}, 32'd0);

        // 1: sweep with all requesters waiting
        applyStimulus(1'b0, 4'b1111);
        #1;
        checkSweep("sweep1", 32);
        checkOutput("sweep1_end_busy", {31'd0, busy}, 32'd0);

        // 3: round robin, first grant to requester 0 in cycle 33
        for (int k = 0; k < 8; k++) begin
            checkOutput("rr_ready", {28'd0, req_ready}, onehot(k % 4));
            tick();
            checkOutput("rr_grant_id", {30'd0, grant_id}, 32'(k % 4));
            checkOutput("rr_wr_en", wr_en, onehot(8 + (k % 4)));
            checkOutput("rr_wr_data", wr_data, 32'hA0 + 32'(k % 4));
        end

        // idle: enables drop, data and grant_id hold
        applyStimulus(1'b0, 4'b0000);
        #1;
        checkOutput("idle_ready", {28'd0, req_ready}, 32'd0);
        tick();
        checkOutput("idle_wr_en", wr_en, 32'd0);
        checkOutput("idle_grant_id", {30'd0, grant_id}, 32'd3);
        checkOutput("idle_wr_data", wr_data, 32'hA3);

        // 2: single write from requester 2
        setReq(2, 5'd5, 32'hDEADBEEF);
        applyStimulus(1'b0, 4'b0100);
        #1;
        checkOutput("single_ready", {28'd0, req_ready}, 32'h4);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("single_wr_en", wr_en, 32'h0000_0020);
        checkOutput("single_wr_data", wr_data, 32'hDEADBEEF);
        checkOutput("single_grant_id", {30'd0, grant_id}, 32'd2);
        tick();
        checkOutput("single_after_wr_en", wr_en, 32'd0);

        // 4: read-only register 0 (pointer is 3, search 3,0,1)
        setReq(1, 5'd0, 32'h12345678);
        applyStimulus(1'b0, 4'b0010);
        #1;
        checkOutput("zero_ready", {28'd0, req_ready}, 32'h2);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("zero_wr_en", wr_en, 32'd0);
        checkOutput("zero_grant_id", {30'd0, grant_id}, 32'd1);
        checkOutput("zero_wr_data", wr_data, 32'h12345678);

        // 6: reset in the same cycle as an accept from requester 3
        setReq(3, 5'd7, 32'h77);
        applyStimulus(1'b0, 4'b1000);
        #1;
        checkOutput("rstw_ready", {28'd0, req_ready}, 32'h8);
        applyStimulus(1'b1, 4'b1000);
        tick();
        checkOutput("rstw_wr_en", wr_en, 32'd0);
        checkOutput("rstw_grant_id", {30'd0, grant_id}, 32'd0);
        checkOutput("rstw_busy", {31'd0, busy}, 32'd1);

        // 5: reset during sweep cycle 10, then a full sweep again
        applyStimulus(1'b0, 4'b0000);
        #1;
        checkSweep("sweep_part", 10);
        applyStimulus(1'b1, 4'b0000);
        tick();
        checkOutput("midsweep_wr_en", wr_en, 32'd0);
        checkOutput("midsweep_busy", {31'd0, busy}, 32'd1);
        applyStimulus(1'b0, 4'b0000);
        #1;
        checkSweep("sweep2", 32);
        checkOutput("sweep2_end_busy", {31'd0, busy}, 32'd0);

        // pointer back at 0: requesters 0 and 3 together, 0 wins first
        applyStimulus(1'b0, 4'b1001);
        #1;
        checkOutput("ptr0_ready", {28'd0, req_ready}, 32'h1);
        tick();
        checkOutput("ptr0_grant_id", {30'd0, grant_id}, 32'd0);
        checkOutput("ptr0_wr_en", wr_en, onehot(8));
        checkOutput("ptr1_ready", {28'd0, req_ready}, 32'h8);
        tick();
        applyStimulus(1'b0, 4'b0000);
        checkOutput("ptr1_grant_id", {30'd0, grant_id}, 32'd3);
        checkOutput("ptr1_wr_en", wr_en, onehot(7));
        checkOutput("ptr1_wr_data", wr_data, 32'h77);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
Name: regfile_wr_arbiter

Overview:
Shares the single write port of the 32 x 32-bit register file between NREQ requesters, using round-robin arbitration.
- Converts each granted request into a registered one-hot write-enable bus, wr_en[31:0], and a data word, wr_data.
- wr_en bit k drives the en input of register k; all registers share wr_data.
- After reset, an optional clear sequencer sweeps zeros through every register before requests are accepted.

Parameters:
NREQ, 4, number of requesters (2..8).
AW, 5, register address width (32 registers).
DW, 32, data width.
CLEAR_ON_RESET, 1, 1 = run the 32-cycle zero sweep after reset; 0 = go straight to RUN.
ZERO_REG, 1, 1 = register 0 is read-only: writes are accepted and acknowledged, but wr_en stays all zero.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  NREQ  request i holds a write.
req_addr  in  NREQ*AW  packed addresses; slice i = [i*AW +: AW].
req_data  in  NREQ*DW  packed data; slice i = [i*DW +: DW].
req_ready  out  NREQ  one-hot grant; write i is accepted when req_valid[i] & req_ready[i].
wr_en  out  2**AW  registered one-hot enables to the register file.
wr_data  out  DW  registered write data.
grant_id  out  $clog2(NREQ)  registered index of the last accepted requester.
busy  out  1  high while the clear sweep runs.

Behaviour:
- Reset (synchronous, active-high):
  - wr_en = 0, wr_data = 0, grant_id = 0.
  - Round-robin pointer = 0.
  - State = CLEAR if CLEAR_ON_RESET, else RUN.
  - Sweep counter = 0.
  - busy = CLEAR_ON_RESET.
- States: CLEAR and RUN only.
- CLEAR:
  - req_ready = 0.
  - Each cycle: wr_en = one-hot(counter), wr_data = 0; counter increments.
  - ZERO_REG does not suppress register 0 during the sweep.
  - In the cycle the counter reaches 31, the next state is RUN and busy falls.
  - The sweep therefore takes exactly 32 cycles. The first accept is possible in cycle 33 after reset release.
- RUN, arbitration (combinational):
  - The search starts at the pointer and runs upward modulo NREQ.
  - The first i with req_valid[i] = 1 gets req_ready[i] = 1. At most one ready bit is high per cycle.
  - req_ready is all zero when no request is valid.
- RUN, on accept of requester i:
  - Next cycle: wr_en = one-hot(addr_i), wr_data = data_i, grant_id = i.
  - Exception: if ZERO_REG and addr_i == 0, wr_en = 0.
  - Pointer becomes (i+1) mod NREQ.
  - With no accept, wr_en = 0 next cycle. wr_data and grant_id hold their values. The pointer holds.
- Latency: accept to wr_en is 1 cycle. Throughput is one write per cycle.
- Requester rules:
  - While req_valid is high and not yet accepted, addr and data stay stable.
  - Requesters never wait on ready before raising valid.
  - A requester may hold valid for back-to-back writes.
- Simultaneous requests:
  - Requests are served in rotation.
  - With all NREQ valid continuously, each requester is granted once every NREQ cycles.
- Reset mid-operation (reset = 1 in any state):
  - Overrides everything. Any pending wr_en is dropped next cycle and the pointer returns to 0.
  - With CLEAR_ON_RESET, the sweep restarts from register 0.
- Register-file timing: wr_en must be registered so the register file captures wr_data on the edge after wr_en rises. No combinational path runs from req_* to wr_en or wr_data.
- Same address from two requesters in consecutive cycles: both writes issue in grant order; the later write wins.

Decomposition:
- Shared package rf_pkg holds:
  - constants RF_AW = 5, RF_DW = 32, RF_DEPTH = 32;
  - the state encoding ST_CLEAR = 1'b0, ST_RUN = 1'b1.
- One natural sub-module, rr_arbiter (NREQ):
  - inputs: req, pointer;
  - outputs: one-hot gnt and its index;
  - purely combinational, reused by future register-file read-port sharing.
- The 5-to-32 one-hot decode stays inline.

Test Plan:
1. CLEAR sweep: CLEAR_ON_RESET = 1; release reset; hold req_valid = 4'b1111.
   -> busy high for exactly 32 cycles; wr_en walks 0x00000001 to 0x80000000 with wr_data = 0; req_ready = 0 throughout; the first grant goes to requester 0 in cycle 33.
2. Single write: req 2 sends addr 5, data 0xDEADBEEF.
   -> req_ready = 4'b0100 the same cycle; next cycle wr_en = 0x00000020, wr_data = 0xDEADBEEF, grant_id = 2; the following cycle wr_en = 0.
3. Round robin: all four valid for 8 cycles, starting from pointer 0.
   -> grant sequence 0, 1, 2, 3, 0, 1, 2, 3; never two ready bits high at once.
4. Zero register: ZERO_REG = 1; req 1 sends addr 0, data 0x12345678.
   -> req_ready[1] = 1 and grant_id = 1, but wr_en stays 0x00000000.
5. Reset mid-sweep: assert reset at sweep cycle 10, then release.
   -> the sweep restarts at wr_en = 0x00000001 and runs a full 32 cycles.
6. Reset mid-write: accept req 3 (addr 7), assert reset in the same cycle.
   -> next cycle wr_en = 0; pointer = 0, so a subsequent simultaneous req 0 / req 3 grants requester 0 first.
